// File: rtl/alu_pkg.sv
// alu_seq shared definitions.
// Opcodes, FSM states and flag bit positions.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_MUL  = 4'b0010;
    localparam logic [3:0] ALU_MULU = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_S = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    function automatic logic is_mul(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_MULU);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq request/response bundle.
// master = register-read side, slave = the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operand0;
    logic [WIDTH-1:0] operand1;
    logic [3:0]       control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zflag;
    logic             carryflag;
    logic             signflag;
    logic             overflowflag;

    modport master (
        output in_valid, operand0, operand1,
        output control, out_ready,
        input  in_ready, out_valid, result,
        input  result_hi, zflag, carryflag,
        input  signflag, overflowflag
    );

    modport slave (
        input  in_valid, operand0, operand1,
        input  control, out_ready,
        output in_ready, out_valid, result,
        output result_hi, zflag, carryflag,
        output signflag, overflowflag
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add unsigned multiplier.
// One partial product per cycle, WIDTH cycles.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod_nxt;

    // add multiplicand into upper half when the current multiplier bit is set
    always_comb begin
        sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
        if (prod_q[0]) begin
            sum = sum + {1'b0, mcand_q};
        end
        prod_nxt = {sum, prod_q[WIDTH-1:1]};
    end

    // done flags the final step; product is the value that step produces
    assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign product = prod_nxt;

    // operand latch and one shift-add step per busy cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (start) begin
            mcand_q <= mcand;
            prod_q  <= {{WIDTH{1'b0}}, mplier};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            prod_q <= prod_nxt;
            cnt_q  <= cnt_q + CW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready on both sides.
// Single-cycle ops plus an iterative signed/unsigned multiply.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);

    state_t state_q, state_d;

    logic             rdy;
    logic             vld;
    logic             accept;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    logic             op_signed;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             mul_start;
    logic             mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH-1:0] mul_hi;
    logic             mul_c;
    logic             mul_v;

    logic             neg_q;
    logic             sgn_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] hi_q;
    logic [3:0]       flags_q;

    assign a      = bus.operand0;
    assign b      = bus.operand1;
    assign op     = bus.control;
    assign accept = bus.in_valid && rdy;
    assign shamt  = b[SHW-1:0];

    // single-cycle datapath: arithmetic, logic, shifts
    always_comb begin
        add_sum = {1'b0, a} + {1'b0, b};
        sub_sum = {1'b0, a} + {1'b0, ~b}
                + {{WIDTH{1'b0}}, 1'b1};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (op)
            ALU_ADD: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1])
                       && (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = sub_sum[WIDTH-1:0];
                alu_c   = sub_sum[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1])
                       && (sub_sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: alu_res = a & b;
            ALU_OR:  alu_res = a | b;
            ALU_XOR: alu_res = a ^ b;
            ALU_NOR: alu_res = ~(a | b);
            ALU_SLL: alu_res = a << shamt;
            ALU_SRL: alu_res = a >> shamt;
            ALU_SRA: alu_res = $signed(a) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // multiply operands go in as magnitudes; sign is restored on exit
    always_comb begin
        op_signed = (op == ALU_MUL);
        a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
        b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;
        mul_start = accept && is_mul(op);
        prod_fix  = neg_q ? -mul_prod : mul_prod;
        mul_lo    = prod_fix[WIDTH-1:0];
        mul_hi    = prod_fix[2*WIDTH-1:WIDTH];
        mul_v     = sgn_q
                 && (mul_hi != {WIDTH{mul_lo[WIDTH-1]}});
        mul_c     = !sgn_q && (mul_hi != '0);
    end

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .mcand  (a_mag),
        .mplier (b_mag),
        .done   (mul_done),
        .product(mul_prod)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and handshake outputs
    always_comb begin
        state_d = state_q;
        rdy     = 1'b0;
        vld     = 1'b0;
        unique case (state_q)
            IDLE: begin
                rdy = 1'b1;
                if (bus.in_valid) begin
                    state_d = is_mul(op) ? MUL : DONE;
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                vld = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // result and flag registers, loaded on accept or multiply completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q   <= '0;
            hi_q    <= '0;
            flags_q <= '0;
            neg_q   <= 1'b0;
            sgn_q   <= 1'b0;
        end else if (accept) begin
            if (is_mul(op)) begin
                sgn_q <= op_signed;
                neg_q <= op_signed
                      && (a[WIDTH-1] ^ b[WIDTH-1]);
            end else begin
                res_q           <= alu_res;
                hi_q            <= '0;
                flags_q[FLAG_Z] <= (alu_res == '0);
                flags_q[FLAG_C] <= alu_c;
                flags_q[FLAG_S] <= alu_res[WIDTH-1];
                flags_q[FLAG_V] <= alu_v;
            end
        end else if (state_q == MUL && mul_done) begin
            res_q           <= mul_lo;
            hi_q            <= mul_hi;
            flags_q[FLAG_Z] <= (prod_fix == '0);
            flags_q[FLAG_C] <= mul_c;
            flags_q[FLAG_S] <= mul_hi[WIDTH-1];
            flags_q[FLAG_V] <= mul_v;
        end
    end

    assign bus.in_ready     = rdy;
    assign bus.out_valid    = vld;
    assign bus.result       = res_q;
    assign bus.result_hi    = hi_q;
    assign bus.zflag        = flags_q[FLAG_Z];
    assign bus.carryflag    = flags_q[FLAG_C];
    assign bus.signflag     = flags_q[FLAG_S];
    assign bus.overflowflag = flags_q[FLAG_V];

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq.
// Directed corner cases followed by random traffic.
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] r;
        logic [31:0] h;
        logic        z;
        logic        c;
        logic        s;
        logic        v;
    } exp_t;

    localparam longint IMAX = (longint'(1) << 31) - 1;
    localparam longint IMIN = -(longint'(1) << 31);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string n,
                                input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endfunction

    function automatic exp_t model(input logic [3:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t e;
        longint sv;
        longint unsigned up;
        logic [32:0] w;
        bit mulop;
        e = '{r: 32'h0, h: 32'h0, z: 1'b0,
              c: 1'b0, s: 1'b0, v: 1'b0};
        mulop = 0;
        case (op)
            4'd0: begin
                w = {1'b0, a} + {1'b0, b};
                e.r = w[31:0];
                e.c = w[32];
                sv = longint'($signed(a)) + longint'($signed(b));
                e.v = (sv > IMAX) || (sv < IMIN);
            end
            4'd1: begin
                e.r = a - b;
                e.c = (a >= b);
                sv = longint'($signed(a)) - longint'($signed(b));
                e.v = (sv > IMAX) || (sv < IMIN);
            end
            4'd2: begin
                mulop = 1;
                sv = longint'($signed(a)) * longint'($signed(b));
                {e.h, e.r} = sv;
                e.v = (sv > IMAX) || (sv < IMIN);
            end
            4'd3: begin
                mulop = 1;
                up = {32'h0, a} * {32'h0, b};
                {e.h, e.r} = up;
                e.c = (e.h != 0);
            end
            4'd4: e.r = a & b;
            4'd5: e.r = a | b;
            4'd6: e.r = a ^ b;
            4'd7: e.r = ~(a | b);
            4'd8: e.r = a << b[4:0];
            4'd9: e.r = a >> b[4:0];
            4'd10: e.r = $signed(a) >>> b[4:0];
            default: e.r = 32'h0;
        endcase
        e.z = mulop ? ({e.h, e.r} == 64'h0) : (e.r == 0);
        e.s = mulop ? e.h[31] : e.r[31];
        return e;
    endfunction

    // monitor: compare every delivered result against the scoreboard
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output got %h",
                         bus.result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", 64'(bus.result), 64'(e.r));
                chk("result_hi", 64'(bus.result_hi), 64'(e.h));
                chk("zflag", 64'(bus.zflag), 64'(e.z));
                chk("carry", 64'(bus.carryflag), 64'(e.c));
                chk("sign", 64'(bus.signflag), 64'(e.s));
                chk("ovf", 64'(bus.overflowflag), 64'(e.v));
            end
        end
    end

    task automatic issue(input logic [3:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input int hold);
        int n;
        int lat;
        bit saw;
        logic [31:0] sr;
        logic [31:0] sh;
        logic [3:0]  sf;
        bus.control  = op;
        bus.operand0 = a;
        bus.operand1 = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 64'(0), 64'(1));
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back(model(op, a, b));
        #1;
        bus.in_valid = 1'b0;
        bus.operand0 = $urandom;
        bus.operand1 = $urandom;
        if (hold > 0) bus.out_ready = 1'b0;
        lat = 1;
        saw = 0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) saw = 1;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 64'(lat), is_mul(op) ? 64'(33) : 64'(1));
        chk("busy_in_ready", 64'(saw), 64'(0));
        if (hold > 0) begin
            sr = bus.result;
            sh = bus.result_hi;
            sf = {bus.overflowflag, bus.signflag,
                  bus.carryflag, bus.zflag};
            for (int i = 0; i < hold; i++) begin
                bus.in_valid = 1'b1;
                bus.control  = ALU_ADD;
                @(posedge clk);
                #1;
                chk("hold_valid", 64'(bus.out_valid), 64'(1));
                chk("hold_ready", 64'(bus.in_ready), 64'(0));
                chk("hold_res", 64'({bus.result_hi, bus.result}),
                    {sh, sr});
                chk("hold_flags",
                    64'({bus.overflowflag, bus.signflag,
                         bus.carryflag, bus.zflag}), 64'(sf));
            end
            bus.in_valid = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("valid_drop", 64'(bus.out_valid), 64'(0));
        chk("ready_back", 64'(bus.in_ready), 64'(1));
    endtask

    logic [31:0] edges [8] = '{32'h0, 32'h1, 32'hFFFFFFFF,
                               32'h80000000, 32'h7FFFFFFF,
                               32'h00010000, 32'h0000001F,
                               32'h00000020};

    function automatic logic [31:0] pick();
        if ($urandom_range(0, 3) == 0)
            return edges[$urandom_range(0, 7)];
        return $urandom;
    endfunction

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.control   = 4'h0;
        bus.operand0  = '0;
        bus.operand1  = '0;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_result", 64'({bus.result_hi, bus.result}), 64'(0));
        chk("rst_flags",
            64'({bus.zflag, bus.carryflag,
                 bus.signflag, bus.overflowflag}), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        issue(ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 0);
        issue(ALU_ADD, 32'hFFFFFFFF, 32'h00000001, 0);
        issue(ALU_SUB, 32'd5, 32'd5, 0);
        issue(ALU_SUB, 32'd0, 32'd1, 0);
        issue(ALU_MUL, 32'hFFFFFFFD, 32'd5, 0);
        issue(ALU_MUL, 32'h80000000, 32'h80000000, 0);
        issue(ALU_MULU, 32'h00010000, 32'h00010000, 0);
        issue(ALU_SRA, 32'h80000000, 32'h00000021, 0);
        issue(ALU_SLL, 32'h12345678, 32'h00000000, 0);
        issue(ALU_XOR, 32'hA5A5A5A5, 32'h0F0F0F0F, 5);
        issue(4'b1100, 32'h12345678, 32'h9ABCDEF0, 0);
        issue(ALU_MUL, 32'hFFFFFFFF, 32'h80000000, 3);

        // reset in the middle of a multiply
        bus.control  = ALU_MUL;
        bus.operand0 = 32'h1234;
        bus.operand1 = 32'h5678;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(bus.out_valid), 64'(0));
        chk("midrst_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1 rst = 1'b0;
        issue(ALU_ADD, 32'd2, 32'd3, 0);

        for (int i = 0; i < 60; i++) begin
            issue(4'($urandom_range(0, 15)), pick(), pick(),
                  int'($urandom_range(0, 2)));
        end

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, multi-cycle successor to the KGP-RISC combinational ALU.
- Adds SUB, a correct signed/unsigned split for multiply, a double-width product, registered flags and valid/ready handshakes on both sides.
- Single-cycle ops return after 1 cycle. Multiplies use an iterative shift-add engine so no wide combinational multiplier is needed.
- Sits between the register-read stage and writeback. The datapath stalls on in_ready/out_valid.

Parameters:
WIDTH, 32, operand/result width; must be a power of two, at least 8.
SHW, $clog2(WIDTH), derived; number of shift-amount bits used from operand1.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
operand0  in  WIDTH  first operand
operand1  in  WIDTH  second operand / shift amount
control  in  4  operation code
out_valid  out  1  result and flags valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  result; low half of the product for multiplies
result_hi  out  WIDTH  high half of the product for multiplies; 0 for all other ops
zflag  out  1  result zero (full 2*WIDTH product for multiplies)
carryflag  out  1  carry/unsigned overflow
signflag  out  1  result[WIDTH-1]; for multiplies, result_hi[WIDTH-1]
overflowflag  out  1  signed overflow

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, result=result_hi=0, all flags=0. Any in-flight multiply is discarded.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 MUL (signed), 0011 MULU (unsigned).
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NOR.
  - 1000 SLL, 1001 SRL, 1010 SRA.
  - 1011-1111 invalid: result=0, zflag=1, other flags 0, latency 1.
- States:
  - IDLE: in_ready=1. On accept (in_valid & in_ready):
    - Non-multiply op: compute, register result+flags, go to DONE. out_valid is high the cycle after accept.
    - MUL/MULU: latch operands, cnt=0, go to MUL.
  - MUL: in_ready=0. One partial-product step per cycle; cnt increments. At cnt==WIDTH-1, register product+flags and go to DONE. out_valid rises WIDTH+1 cycles after the accept edge (33 for WIDTH=32).
  - DONE: out_valid=1, in_ready=0. On out_ready go to IDLE; out_valid is 0 next cycle. Outputs stay stable while out_ready=0.
- Throughput: one request per (latency+1) cycles. There is no overlap of accept and output.
- Arithmetic and flag rules:
  - ADD: {carry,result} = op0+op1. V = (op0 sign == op1 sign) && (result sign != op0 sign).
  - SUB: computed as op0 + ~op1 + 1; C = carry-out of that add (1 = no borrow). V = (op0 sign != op1 sign) && (result sign != op0 sign).
  - MULU: 2*WIDTH unsigned product. C = (result_hi != 0). V = 0.
  - MUL: magnitudes are multiplied unsigned; the product is negated if the operand signs differ. Most-negative operands are handled correctly: -2^(W-1) * -2^(W-1) = 2^(2W-2). V = (result_hi is not all copies of result[WIDTH-1]). C = 0.
  - Shifts: amount = operand1[SHW-1:0]; upper bits are ignored. C = V = 0.
  - Logic ops: C = V = 0.
  - zflag/signflag always follow the registered result (product for multiplies).
- Boundaries:
  - in_valid while busy is ignored; the requester must hold it.
  - out_ready is ignored outside DONE.
  - Shift by 0 leaves the operand unchanged.
  - Reset mid-multiply returns to IDLE with in_ready=1 after deassertion.

Decomposition:
- alu_pkg: opcode localparams (ALU_ADD..ALU_SRA), state enum {IDLE, MUL, DONE}, flag bit indices.
- One sub-module, alu_mul_iter:
  - Function: radix-2 shift-add unsigned WIDTH x WIDTH.
  - Interface: start, operands in; done, product out.
  - Sign handling stays in alu_seq.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, S=1, V=1, C=0, Z=0; out_valid the cycle after accept.
- ADD 0xFFFFFFFF + 0x00000001 -> result 0, Z=1, C=1, V=0. SUB 5-5 -> Z=1, C=1. SUB 0-1 -> 0xFFFFFFFF, C=0, S=1.
- MUL 0xFFFFFFFD (-3) x 5 -> result 0xFFFFFFF1, result_hi 0xFFFFFFFF, V=0, S=1. in_ready=0 for 33 cycles, then out_valid. MUL 0x80000000 x 0x80000000 -> hi 0x40000000, lo 0, V=1.
- MULU 0x00010000 x 0x00010000 -> result 0, result_hi 1, C=1, Z=0. SRA 0x80000000 by operand1=0x21 (amount 1) -> 0xC0000000.
- Hold out_ready=0 for 5 cycles in DONE -> result/flags/out_valid stable; new in_valid is ignored until the handshake completes. Opcode 1100 -> result 0, Z=1.
- Assert rst at cycle 10 of a MUL -> out_valid=0, in_ready=1 immediately. A following ADD 2+3 returns 5 with 1-cycle latency.
